// File: rtl/ttt_board_renderer.sv
// rtl/ttt_board_renderer.sv - tic-tac-toe pixel colour stage, 3-cycle pipeline with per-frame snapshot
module ttt_board_renderer #(
  parameter int X0           = 95,
  parameter int Y0           = 15,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [17:0] board,
  input  logic [3:0]  cursor,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [9:0] X0_V = 10'(X0);
  localparam logic [9:0] Y0_V = 10'(Y0);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FC_LAST = FW'(BLINK_FRAMES - 1);

  logic          prev_vs;
  logic [17:0]   snap_board;
  logic [3:0]    snap_cursor;
  logic [FW-1:0] frame_cnt;
  logic          blink;

  // Frame event: snapshot board/cursor and advance the blink counter on vsync fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_vs     <= 1'b1;
      snap_board  <= '0;
      snap_cursor <= 4'hF;
      frame_cnt   <= '0;
      blink       <= 1'b1;
    end else begin
      prev_vs <= vsync_in;
      if (prev_vs && !vsync_in) begin
        snap_board  <= board;
        snap_cursor <= cursor;
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- S1: locate ----------------
  logic [9:0] bx_c, by_c;
  logic [7:0] u_c, v_c;
  logic [1:0] col_c, row_c;
  logic       inb_c;

  // Board-relative coordinates, cell column/row and in-cell offsets by range compare
  always_comb begin
    bx_c  = x - X0_V;
    by_c  = y - Y0_V;
    inb_c = (x >= X0_V) && (bx_c < 10'd450) && (y >= Y0_V) && (by_c < 10'd450);
    if (bx_c < 10'd150) begin
      col_c = 2'd0; u_c = bx_c[7:0];
    end else if (bx_c < 10'd300) begin
      col_c = 2'd1; u_c = 8'(bx_c - 10'd150);
    end else begin
      col_c = 2'd2; u_c = 8'(bx_c - 10'd300);
    end
    if (by_c < 10'd150) begin
      row_c = 2'd0; v_c = by_c[7:0];
    end else if (by_c < 10'd300) begin
      row_c = 2'd1; v_c = 8'(by_c - 10'd150);
    end else begin
      row_c = 2'd2; v_c = 8'(by_c - 10'd300);
    end
  end

  logic       s1_en, s1_hs, s1_vs, s1_inb;
  logic [8:0] s1_bx, s1_by;
  logic [1:0] s1_col, s1_row;
  logic [7:0] s1_u, s1_v;

  // S1 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_en <= 1'b0; s1_hs <= 1'b1; s1_vs <= 1'b1; s1_inb <= 1'b0;
      s1_bx <= '0; s1_by <= '0; s1_col <= '0; s1_row <= '0;
      s1_u <= '0; s1_v <= '0;
    end else begin
      s1_en <= en; s1_hs <= hsync_in; s1_vs <= vsync_in; s1_inb <= inb_c;
      s1_bx <= bx_c[8:0]; s1_by <= by_c[8:0]; s1_col <= col_c; s1_row <= row_c;
      s1_u <= u_c; s1_v <= v_c;
    end
  end

  // ---------------- S2: measure ----------------
  logic signed [8:0]  dx_c, dy_c;
  logic signed [13:0] dx2_c, dy2_c;
  logic [13:0] r2_c;
  logic [7:0]  d1_c;
  logic [8:0]  sum_c, d2_c;
  logic        grid_c, hl_c;
  logic [3:0]  idx_c;
  logic [1:0]  code_c;

  // Distances from centre and diagonals, grid lines, cell code and cursor match
  always_comb begin
    dx_c   = $signed({1'b0, s1_u}) - 9'sd75;
    dy_c   = $signed({1'b0, s1_v}) - 9'sd75;
    dx2_c  = 14'(dx_c) * 14'(dx_c);
    dy2_c  = 14'(dy_c) * 14'(dy_c);
    r2_c   = $unsigned(dx2_c) + $unsigned(dy2_c);
    d1_c   = (s1_u >= s1_v) ? (s1_u - s1_v) : (s1_v - s1_u);
    sum_c  = {1'b0, s1_u} + {1'b0, s1_v};
    d2_c   = (sum_c >= 9'd149) ? (sum_c - 9'd149) : (9'd149 - sum_c);
    grid_c = (s1_bx >= 9'd148 && s1_bx <= 9'd151) || (s1_bx >= 9'd298 && s1_bx <= 9'd301) ||
             (s1_by >= 9'd148 && s1_by <= 9'd151) || (s1_by >= 9'd298 && s1_by <= 9'd301);
    idx_c  = {2'b00, s1_row} * 4'd3 + {2'b00, s1_col};
    code_c = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (idx_c == 4'(i)) code_c = snap_board[2*i +: 2];
    end
    hl_c = blink && (snap_cursor == idx_c);
  end

  logic        s2_en, s2_hs, s2_vs, s2_inb, s2_grid, s2_hl;
  logic [7:0]  s2_u, s2_v, s2_d1;
  logic [8:0]  s2_d2;
  logic [13:0] s2_r2;
  logic [1:0]  s2_code;

  // S2 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_en <= 1'b0; s2_hs <= 1'b1; s2_vs <= 1'b1; s2_inb <= 1'b0;
      s2_grid <= 1'b0; s2_hl <= 1'b0; s2_u <= '0; s2_v <= '0;
      s2_d1 <= '0; s2_d2 <= '0; s2_r2 <= '0; s2_code <= '0;
    end else begin
      s2_en <= s1_en; s2_hs <= s1_hs; s2_vs <= s1_vs; s2_inb <= s1_inb;
      s2_grid <= grid_c; s2_hl <= hl_c; s2_u <= s1_u; s2_v <= s1_v;
      s2_d1 <= d1_c; s2_d2 <= d2_c; s2_r2 <= r2_c; s2_code <= code_c;
    end
  end

  // ---------------- S3: colour ----------------
  logic border_c, xmark_c, omark_c;

  // Cursor frame, X stroke and O ring tests
  always_comb begin
    border_c = (s2_u < 8'd3) || (s2_u > 8'd146) || (s2_v < 8'd3) || (s2_v > 8'd146);
    xmark_c  = (s2_code == 2'b01) && (s2_u >= 8'd20) && (s2_u <= 8'd129) &&
               (s2_v >= 8'd20) && (s2_v <= 8'd129) && ((s2_d1 <= 8'd4) || (s2_d2 <= 9'd4));
    omark_c  = (s2_code == 2'b10) && (s2_r2 >= 14'd2025) && (s2_r2 <= 14'd3025);
  end

  // Output register: priority colour select, syncs aligned with rgb
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= 12'h000; hsync_out <= 1'b1; vsync_out <= 1'b1;
    end else begin
      hsync_out <= s2_hs;
      vsync_out <= s2_vs;
      if (!s2_en || !s2_inb)          rgb <= 12'h000;
      else if (s2_grid)               rgb <= 12'hFFF;
      else if (s2_hl && border_c)     rgb <= 12'hFF0;
      else if (xmark_c)               rgb <= 12'hF00;
      else if (omark_c)               rgb <= 12'h00F;
      else                            rgb <= 12'h222;
    end
  end

endmodule

// File: tb/tb_ttt_board_renderer.sv
// tb/tb_ttt_board_renderer.sv - self-checking bench for ttt_board_renderer
module tb_ttt_board_renderer;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        en, hsync_in, vsync_in;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  ttt_board_renderer dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .en(en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .board(board), .cursor(cursor),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit          frame;
    logic [17:0] brd;
    logic [3:0]  cur;
    logic [9:0]  px, py;
    logic        pen;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    logic [11:0] rgb;
    logic        hs, vs;
    bit          chk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic [9:0] px, input logic [9:0] py, input logic pen,
                      input logic hs, input logic vs, input logic [11:0] exp, input bit chk);
    exp_t e;
    @(negedge clk);
    x = px; y = py; en = pen; hsync_in = hs; vsync_in = vs;
    e.rgb = exp; e.hs = hs; e.vs = vs; e.chk = chk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 3) begin
      e = sb.pop_front();
      if (e.chk) check("rgb", rgb, e.rgb);
      check("hsync_out", {11'd0, hsync_out}, {11'd0, e.hs});
      check("vsync_out", {11'd0, vsync_out}, {11'd0, e.vs});
    end
  endtask

  task automatic vsync_pulse();
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
  endtask

  function automatic vec_t mk(bit f, logic [17:0] b, logic [3:0] c,
                              int px, int py, logic pe, logic [11:0] ex);
    vec_t v;
    v.frame = f; v.brd = b; v.cur = c; v.px = 10'(px); v.py = 10'(py); v.pen = pe; v.exp = ex;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; en = 1'b1; x = 10'd170; y = 10'd90;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset rgb", rgb, 12'h000);
    check("reset hsync_out", {11'd0, hsync_out}, 12'd1);
    check("reset vsync_out", {11'd0, vsync_out}, 12'd1);
    @(negedge clk);
    hsync_in = 1'b1; vsync_in = 1'b1; en = 1'b0;
    reset = 1'b0;
  endtask

  int  cnt;
  bit  bl;

  initial begin
    reset = 1'b1; x = '0; y = '0; en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    board = '0; cursor = 4'hF;

    vecs.push_back(mk(0, 18'h0, 4'hF, 243, 100, 1, 12'hFFF));
    vecs.push_back(mk(0, 18'h0, 4'hF, 243, 100, 0, 12'h000));
    vecs.push_back(mk(0, 18'h0, 4'hF,  50, 100, 1, 12'h000));
    vecs.push_back(mk(0, 18'h0, 4'hF, 170,  90, 1, 12'h222));
    vecs.push_back(mk(1, 18'h1, 4'hF, 170,  90, 1, 12'hF00));
    vecs.push_back(mk(0, 18'h1, 4'hF, 200,  90, 1, 12'h222));
    vecs.push_back(mk(0, 18'h1, 4'hF, 115,  35, 1, 12'hF00));
    vecs.push_back(mk(0, 18'h1, 4'hF, 114,  34, 1, 12'h222));
    vecs.push_back(mk(1, 18'h2, 4'hF, 220,  90, 1, 12'h00F));
    vecs.push_back(mk(0, 18'h2, 4'hF, 170,  90, 1, 12'h222));
    vecs.push_back(mk(0, 18'h2, 4'hF, 215,  90, 1, 12'h00F));
    vecs.push_back(mk(0, 18'h2, 4'hF, 225,  90, 1, 12'h00F));
    vecs.push_back(mk(0, 18'h2, 4'hF, 226,  90, 1, 12'h222));
    vecs.push_back(mk(0, 18'h2, 4'hF, 214,  90, 1, 12'h222));
    vecs.push_back(mk(1, 18'h2, 4'h4, 320, 167, 1, 12'hFF0));
    vecs.push_back(mk(0, 18'h2, 4'h4, 320, 166, 1, 12'hFFF));
    vecs.push_back(mk(0, 18'h1, 4'h4, 220,  90, 1, 12'h00F));
    vecs.push_back(mk(1, 18'h1, 4'h4, 220,  90, 1, 12'h222));
    vecs.push_back(mk(0, 18'h1, 4'h4, 170,  90, 1, 12'hF00));
    vecs.push_back(mk(0, 18'h1, 4'hC, 320, 167, 1, 12'hFF0));
    vecs.push_back(mk(1, 18'h1, 4'hC, 320, 167, 1, 12'h222));
    vecs.push_back(mk(1, 18'h3, 4'hC, 170,  90, 1, 12'h222));
    vecs.push_back(mk(0, 18'h3, 4'hC, 545,  90, 1, 12'h000));
    vecs.push_back(mk(0, 18'h3, 4'hC, 544,  90, 1, 12'h222));

    do_reset();

    // hsync latency: one-cycle low pulse must reach hsync_out on the third edge
    @(negedge clk); hsync_in = 1'b0;
    @(posedge clk); #1; check("hs lat edge1", {11'd0, hsync_out}, 12'd1);
    @(negedge clk); hsync_in = 1'b1;
    @(posedge clk); #1; check("hs lat edge2", {11'd0, hsync_out}, 12'd1);
    @(posedge clk); #1; check("hs lat edge3", {11'd0, hsync_out}, 12'd0);
    @(posedge clk); #1; check("hs lat edge4", {11'd0, hsync_out}, 12'd1);

    foreach (vecs[i]) begin
      board = vecs[i].brd;
      cursor = vecs[i].cur;
      if (vecs[i].frame) vsync_pulse();
      step(vecs[i].px, vecs[i].py, vecs[i].pen, 1'b1, 1'b1, vecs[i].exp, 1'b1);
    end
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0);

    // Mid-frame reset blanks output immediately
    step(10'd243, 10'd100, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    step(10'd243, 10'd100, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    step(10'd243, 10'd100, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async reset rgb", rgb, 12'h000);
    do_reset();

    // Blink: count vsync falls with cursor on cell 4
    board = '0; cursor = 4'h4;
    cnt = 0; bl = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      vsync_pulse();
      if (cnt == 29) begin cnt = 0; bl = ~bl; end
      else cnt++;
      step(10'd320, 10'd167, 1'b1, 1'b1, 1'b1, bl ? 12'hFF0 : 12'h222, 1'b1);
    end
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
